// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM block.
// Optional per-channel output inversion is enabled by PWM_INVERT_EN.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_PRESC_W  = 8;

endpackage

// File: rtl/pwm_timebase.sv
// Shared prescaled up / up-down counter with period and mode shadowing.
// load marks every clock in which channel shadows must take new values.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc_div,
    input  logic [WIDTH-1:0]   period,
    input  logic               center_mode,
    output logic [WIDTH-1:0]   cnt,
    output logic               load,
    output logic               period_start
);

    logic [PRESC_W-1:0] pc;
    logic [WIDTH-1:0]   period_sh;
    logic               mode_sh;
    dir_t               dir;
    logic               tick;
    logic               boundary;

    assign tick = en && (pc == presc_div);

    // Boundary is the tick whose successor count is zero.
    always_comb begin
        if (mode_sh == MODE_CENTER) begin
            boundary = ((dir == DIR_DOWN) && (cnt == WIDTH'(1)))
                       || (period_sh == '0);
        end else begin
            boundary = (cnt == period_sh);
        end
    end

    assign load = !en || (tick && boundary);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= '0;
            cnt          <= '0;
            dir          <= DIR_UP;
            period_sh    <= '0;
            mode_sh      <= MODE_EDGE;
            period_start <= 1'b0;
        end else if (!en) begin
            pc           <= '0;
            cnt          <= '0;
            dir          <= DIR_UP;
            period_sh    <= period;
            mode_sh      <= center_mode;
            period_start <= 1'b0;
        end else begin
            period_start <= tick && boundary;
            // Live divisor: an out-of-range pc after a change wraps at once.
            if (pc >= presc_div) pc <= '0;
            else                 pc <= pc + 1'b1;
            if (tick) begin
                if (boundary) begin
                    cnt       <= '0;
                    dir       <= DIR_UP;
                    period_sh <= period;
                    mode_sh   <= center_mode;
                end else if (mode_sh == MODE_CENTER && dir == DIR_DOWN) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                    if (mode_sh == MODE_CENTER && cnt == period_sh - 1'b1)
                        dir <= DIR_DOWN;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_multi_channel.sv
// CHANNELS double-buffered PWM outputs on one shared timebase.
// Define PWM_INVERT_EN to add the per-channel polarity input pol.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PRESC_W  = DEF_PRESC_W,
    localparam int AW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PRESC_W-1:0]  presc_div,
    input  logic [WIDTH-1:0]    period,
    input  logic                center_mode,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
`ifdef PWM_INVERT_EN
    input  logic [CHANNELS-1:0] pol,
`endif
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    logic [WIDTH-1:0]    cnt;
    logic                load;
    logic [CHANNELS-1:0] cmp;
    logic [CHANNELS-1:0] pol_sh;

    pwm_timebase #(
        .WIDTH   (WIDTH),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .presc_div    (presc_div),
        .period       (period),
        .center_mode  (center_mode),
        .cnt          (cnt),
        .load         (load),
        .period_start (period_start)
    );

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [AW-1:0] ID = AW'(i);
        logic [WIDTH-1:0] staged;
        logic [WIDTH-1:0] shadow;

        // Shadow samples staged before a same-clock write lands.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                staged <= '0;
                shadow <= '0;
            end else begin
                if (wr_en && wr_addr == ID) staged <= wr_data;
                if (load) shadow <= staged;
            end
        end

        assign cmp[i] = (cnt < shadow);
    end

`ifdef PWM_INVERT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       pol_sh <= '0;
        else if (load) pol_sh <= pol;
    end
`else
    assign pol_sh = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     pwm_out <= '0;
        else if (en) pwm_out <= cmp ^ pol_sh;
        else         pwm_out <= pol_sh;
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Randomized bench for pwm_multi_channel against a period-phase model.
// Also builds with PWM_INVERT_EN, driving random polarity.
module tb_pwm_multi_channel;

    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [7:0]    presc_div;
    logic [7:0]    period;
    logic          center_mode;
    logic          wr_en;
    logic [1:0]    wr_addr;
    logic [7:0]    wr_data;
    logic [CH-1:0] pol;
    logic [CH-1:0] pwm_out;
    logic          period_start;

    int n_cmp = 0;
    int n_err = 0;

    // Model: position k within the current period, not a counter/direction.
    int            m_pc, m_k, m_P;
    bit            m_mode;
    int            m_st [CH];
    int            m_sh [CH];
    logic [CH-1:0] m_pol;
    logic [CH-1:0] exp_pwm;
    logic          exp_ps;

    always #5 clk = ~clk;

    pwm_multi_channel dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .presc_div    (presc_div),
        .period       (period),
        .center_mode  (center_mode),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
`ifdef PWM_INVERT_EN
        .pol          (pol),
`endif
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    task automatic check(input string tag, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h want %0h", tag, $time, got, want);
        end
    endtask

    function automatic int plen(int p, bit c);
        if (!c) return p + 1;
        return (p == 0) ? 1 : 2 * p;
    endfunction

    function automatic int pcnt(int k, int p, bit c);
        if (c && k > p) return 2 * p - k;
        return k;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_k = 0; m_P = 0; m_mode = 0; m_pol = '0;
        for (int i = 0; i < CH; i++) begin
            m_st[i] = 0;
            m_sh[i] = 0;
        end
        exp_pwm = '0;
        exp_ps  = 1'b0;
    endtask

    task automatic model_load();
        for (int i = 0; i < CH; i++) m_sh[i] = m_st[i];
        m_P    = period;
        m_mode = center_mode;
        m_pol  = pol;
    endtask

    task automatic model_step();
        int            c;
        bit            tick, last;
        logic [CH-1:0] nxt;
        c = pcnt(m_k, m_P, m_mode);
        for (int i = 0; i < CH; i++)
            nxt[i] = en ? ((c < m_sh[i]) ^ m_pol[i]) : m_pol[i];
        tick = en && (m_pc == int'(presc_div));
        last = tick && (m_k == plen(m_P, m_mode) - 1);
        exp_ps = last;
        if (!en) begin
            m_pc = 0;
            m_k  = 0;
            model_load();
        end else begin
            m_pc = (m_pc >= int'(presc_div)) ? 0 : m_pc + 1;
            if (last) begin
                m_k = 0;
                model_load();
            end else if (tick) begin
                m_k++;
            end
        end
        if (wr_en) m_st[wr_addr] = wr_data;
        exp_pwm = nxt;
    endtask

    // Called at a negedge with inputs already set for the next posedge.
    task automatic cyc();
        model_step();
        @(negedge clk);
        check("pwm_out", pwm_out, exp_pwm);
        check("period_start", period_start, exp_ps);
    endtask

    task automatic wr(input int ch, input int d);
        wr_en = 1'b1; wr_addr = 2'(ch); wr_data = 8'(d);
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic setup(input int pd, input int p, input bit c,
                         input int d0, input int d1, input int d2, input int d3);
        en = 1'b0; presc_div = 8'(pd); period = 8'(p); center_mode = c;
        wr(0, d0); wr(1, d1); wr(2, d2); wr(3, d3);
        en = 1'b1;
    endtask

    task automatic run(input int n, input int wr_pct);
        for (int t = 0; t < n; t++) begin
            if ($urandom_range(99) < wr_pct) begin
                wr_en = 1'b1;
                wr_addr = 2'($urandom_range(3));
                wr_data = 8'($urandom_range(int'(period) + 2));
            end
            cyc();
            wr_en = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; presc_div = '0; period = '0;
        center_mode = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        pol = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_pwm", pwm_out, 0);
        check("reset_pstart", period_start, 0);
        rst = 1'b0;

        setup(0, 9, 0, 3, 0, 10, 5);
        run(60, 0);
        setup(0, 4, 1, 2, 0, 5, 4);
        run(40, 0);
        setup(3, 9, 0, 3, 3, 3, 3);
        run(120, 0);

        // Write at a random phase, then one on the boundary clock.
        setup(0, 9, 0, 3, 1, 1, 1);
        run(4, 0);
        wr(0, 7);
        for (int t = 0; t < 40 && !(m_k == 9 && exp_pwm[0] == 1'b0); t++) cyc();
        wr(0, 5);
        run(40, 0);

        // Mode toggle mid-period, then disable/re-enable.
        setup(1, 5, 0, 2, 4, 6, 0);
        run(7, 0);
        center_mode = 1'b1;
        run(30, 0);
        en = 1'b0;
        run(3, 0);
        en = 1'b1;
        run(30, 0);

        // Async reset while an output is high.
        setup(0, 9, 0, 5, 5, 5, 5);
        for (int t = 0; t < 50 && pwm_out == '0; t++) cyc();
        check("rst_setup_high", int'(pwm_out != '0), 1);
        #2 rst = 1'b1;
        #1 check("async_rst_pwm", pwm_out, 0);
        model_reset();
        @(negedge clk);
        check("rst_hold_pwm", pwm_out, 0);
        rst = 1'b0;
        run(30, 0);

        for (int s = 0; s < 30; s++) begin
            presc_div   = 8'($urandom_range(3));
            period      = 8'($urandom_range(12));
            center_mode = 1'($urandom_range(1));
`ifdef PWM_INVERT_EN
            pol = 4'($urandom_range(15));
`endif
            en = 1'b1;
            run(100, 15);
            if ($urandom_range(3) == 0) begin
                period = 8'($urandom_range(12));
                center_mode = ~center_mode;
            end
            run(50, 15);
            if ($urandom_range(2) == 0) begin
                en = 1'b0;
                run($urandom_range(1, 4), 30);
                en = 1'b1;
            end
            presc_div = 8'($urandom_range(2));
            run(40, 10);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_multi_channel.md
Name: pwm_multi_channel

Overview:
- Parametrised successor to the single-channel selectable PWM: CHANNELS independent PWM outputs share one prescaled WIDTH-bit timebase.
- Timebase supports edge-aligned and center-aligned modes.
- Per-channel duty values are written through a simple register port and double-buffered, so updates land only at period boundaries (glitch-free).
- Sits behind the tt_um top-level IO mapping.

Parameters:
CHANNELS, 4, number of PWM outputs (>=1)
WIDTH, 8, counter/duty/period width
PRESC_W, 8, prescaler divisor width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
en  input  1  timebase enable
presc_div  input  PRESC_W  timebase advances every presc_div+1 clocks
period  input  WIDTH  period value P, sampled at boundary
center_mode  input  1  0=edge-aligned, 1=center-aligned; sampled at boundary
wr_en  input  1  duty write strobe
wr_addr  input  $clog2(CHANNELS) (min 1)  channel index
wr_data  input  WIDTH  duty value D
pwm_out  output  CHANNELS  PWM outputs, registered
period_start  output  1  one-clock pulse at each period boundary

Behaviour:
- Reset (async, immediate):
  - all registers 0: staged duty, shadow duty, period_sh, mode_sh, prescaler, cnt, dir=up.
  - pwm_out=0, period_start=0.
- Prescaler:
  - pc counts 0..presc_div.
  - tick asserts when pc==presc_div, then pc wraps to 0.
  - presc_div=0 gives a tick every clock.
  - presc_div is used live, not shadowed. If pc>presc_div after a change, pc wraps to 0 on the next clock.
- Edge mode, per tick: cnt 0,1,...,P then 0. Period = P+1 ticks.
- Center mode, per tick:
  - sequence 0,1,...,P,P-1,...,1 then 0. Period = 2P ticks.
  - dir flips to down on reaching P and back to up on reaching 0.
- P=0 (either mode): cnt stays 0 and every tick is a boundary.
- Boundary = the tick whose next cnt is 0:
  - edge mode: cnt==P.
  - center mode: dir down and cnt==1, or P==0.
- On a boundary:
  - shadow duty[i] <= staged duty[i]; period_sh <= period; mode_sh <= center_mode.
  - cnt <= 0, dir <= up.
  - period_start pulses high for exactly one clock (the clock after the boundary tick, aligned with cnt=0).
- Duty writes:
  - wr_en with wr_addr<CHANNELS writes staged duty[wr_addr].
  - wr_addr>=CHANNELS is ignored.
  - a write in the same clock as a boundary is NOT captured; the shadow takes the prior staged value and the write applies at the next boundary.
- Output:
  - pwm_out[i] <= (cnt < shadow_duty[i]), one clock after cnt.
  - D=0 gives constant low. D>P (edge) or D>P (center) gives constant high.
  - Compare is unsigned at WIDTH bits; no overflow possible.
- en=0:
  - pc=0, cnt=0, dir=up, pwm_out=idle level (0), period_start=0.
  - shadows load from staged/inputs every clock, so the first period after en rises uses the latest values.
- en rising: the first tick occurs presc_div+1 clocks later. cnt=0 is output-valid from the first clock.
- Reset mid-operation: outputs drop asynchronously. Behaviour restarts as from power-on after rst deasserts.

Optional Feature:
- Macro PWM_INVERT_EN.
- Defined:
  - adds port pol input CHANNELS (per-channel polarity).
  - pol is shadowed at boundaries like duty.
  - pwm_out[i] = compare XOR pol_sh[i].
  - idle level while en=0 is pol_sh[i]. Reset value of pol_sh is 0.
- Undefined: no pol port; outputs non-inverted; idle level 0.

Decomposition:
- Package pwm_pkg:
  - mode encoding constants MODE_EDGE=1'b0, MODE_CENTER=1'b1.
  - direction constants DIR_UP/DIR_DOWN.
  - default parameter constants.
- Sub-module pwm_timebase: prescaler, cnt/dir, boundary and period_start generation, period/mode shadowing.
- Top pwm_multi_channel: duty register file, per-channel shadow and compare.

Test Plan:
- Edge: presc=0, P=9, D[0]=3, D[1]=0, D[2]=10, D[3]=5, en=1 -> ch0 high 3 of every 10 clocks; ch1 constant 0; ch2 constant 1; ch3 high 5/10; period_start every 10 clocks.
- Center: P=4, D[0]=2, center_mode=1 -> period 8 clocks, cnt seq 0,1,2,3,4,3,2,1; ch0 high for cnt 0,1 and the down-count 1 (3 of 8); period_start every 8 clocks.
- Prescaler: presc_div=3, P=9, D=3, edge -> each count lasts 4 clocks; high 12 of every 40 clocks.
- Double-buffer: P=9, D[0]=3; write D[0]=7 at cnt=4 -> current period stays 3-high; next period (after period_start) 7-high. A write on the boundary clock is delayed one further period.
- Mode switch / disable: toggle center_mode mid-period -> takes effect at next boundary. Drop en -> pwm_out=0 next clock and cnt=0. Reassert en -> period restarts from cnt=0.
- Async reset mid-period with outputs high -> pwm_out=0 without a clock edge. After release, all duties are 0 and outputs stay low until written.
